// File: rtl/lt24_pic_blit.sv
// lt24_pic_blit: copies a background window into contiguous picture memory over the s2 ports.
// Optional colour-key transparency is enabled by defining LT24_BLIT_COLOR_KEY_EN.
module lt24_pic_blit #(
    parameter int BG_AW     = 13,
    parameter int PIC_AW    = 12,
    parameter int DW        = 16,
    parameter int BG_STRIDE = 128,
    parameter int RD_LAT    = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [BG_AW-1:0]  src_base,
    input  logic [PIC_AW-1:0] dst_base,
    input  logic [7:0]        win_w,
    input  logic [7:0]        win_h,
`ifdef LT24_BLIT_COLOR_KEY_EN
    input  logic [DW-1:0]     key_color,
    input  logic [0:0]        key_en,
`endif
    output logic              busy,
    output logic              done,
    output logic [BG_AW-1:0]  bg_address,
    output logic              bg_chipselect,
    output logic              bg_clken,
    output logic              bg_write,
    output logic [DW-1:0]     bg_writedata,
    output logic [1:0]        bg_byteenable,
    input  logic [DW-1:0]     bg_readdata,
    output logic [PIC_AW-1:0] pic_address,
    output logic              pic_chipselect,
    output logic              pic_clken,
    output logic              pic_write,
    output logic [DW-1:0]     pic_writedata,
    output logic [1:0]        pic_byteenable
);
    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t            r_state;
    logic [7:0]        r_w;
    logic [7:0]        r_col;
    logic [15:0]       r_cnt;
    logic [BG_AW-1:0]  r_row;
    logic [BG_AW-1:0]  r_bg_addr;
    logic [PIC_AW-1:0] r_dst;
    logic [1:0]        r_dcnt;
    logic              r_busy;
    logic              r_done;
    logic              r_rd;
    logic              r_clken;
    logic              r_vld [RD_LAT];
    logic [PIC_AW-1:0] r_adr [RD_LAT];
    logic              w_skip;
    logic              w_wr_slot;

`ifdef LT24_BLIT_COLOR_KEY_EN
    logic [DW-1:0]     r_key;
    logic              r_key_en;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_key    <= '0;
            r_key_en <= 1'b0;
        end else if (r_state == IDLE && start) begin
            r_key    <= key_color;
            r_key_en <= key_en[0];
        end
    end
    assign w_skip = r_key_en && (bg_readdata == r_key);
`else
    assign w_skip = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_w       <= '0;
            r_col     <= '0;
            r_cnt     <= '0;
            r_row     <= '0;
            r_bg_addr <= '0;
            r_dst     <= '0;
            r_dcnt    <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_rd      <= 1'b0;
            r_clken   <= 1'b0;
            for (int k = 0; k < RD_LAT; k++) begin
                r_vld[k] <= 1'b0;
                r_adr[k] <= '0;
            end
        end else begin
            r_clken  <= 1'b1;
            r_vld[0] <= r_rd;
            r_adr[0] <= r_dst;
            for (int k = 1; k < RD_LAT; k++) begin
                r_vld[k] <= r_vld[k-1];
                r_adr[k] <= r_adr[k-1];
            end
            case (r_state)
                IDLE: if (start) begin
                    r_w       <= win_w;
                    r_cnt     <= 16'(win_w) * 16'(win_h);
                    r_col     <= '0;
                    r_row     <= src_base;
                    r_bg_addr <= src_base;
                    r_dst     <= dst_base;
                    if (win_w == 8'd0 || win_h == 8'd0) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= READ;
                        r_rd    <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                READ: begin
                    r_dst <= r_dst + 1'b1;
                    if (r_cnt == 16'd1) begin
                        r_state <= DRAIN;
                        r_rd    <= 1'b0;
                        r_dcnt  <= '0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                        // row wrap restarts from the row pointer, so column never spills into the next row
                        if (r_col == r_w - 8'd1) begin
                            r_col     <= '0;
                            r_row     <= r_row + BG_AW'(BG_STRIDE);
                            r_bg_addr <= r_row + BG_AW'(BG_STRIDE);
                        end else begin
                            r_col     <= r_col + 1'b1;
                            r_bg_addr <= r_bg_addr + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (r_dcnt == 2'(RD_LAT - 1)) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_dcnt <= r_dcnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign w_wr_slot      = r_vld[RD_LAT-1];
    assign busy           = r_busy;
    assign done           = r_done;
    assign bg_address     = r_bg_addr;
    assign bg_chipselect  = r_rd;
    assign bg_clken       = r_clken;
    assign bg_write       = 1'b0;
    assign bg_writedata   = '0;
    assign bg_byteenable  = 2'b11;
    assign pic_address    = r_adr[RD_LAT-1];
    assign pic_chipselect = w_wr_slot;
    assign pic_clken      = r_clken;
    assign pic_write      = w_wr_slot && !w_skip;
    assign pic_writedata  = w_wr_slot ? bg_readdata : '0;
    assign pic_byteenable = 2'b11;
endmodule

// File: doc/lt24_pic_blit.md
Name: lt24_pic_blit

Overview:
- Avalon-style master for the second ports of the two on-chip frame memories: s2 of the background memory and s2 of the picture memory.
- Copies a rectangular window of 16-bit RGB565 pixels from the background memory into a contiguous region of the picture memory.
- The picture memory is then pushed to the LT24 by the Nios software.
- Sits in fabric beside the SOPC and is kicked by a start pulse from control logic.

Parameters:
- BG_AW, 13, background s2 address width (words)
- PIC_AW, 12, picture s2 address width (words)
- DW, 16, pixel/data width
- BG_STRIDE, 128, background row pitch in words
- RD_LAT, 1, background s2 read latency in cycles (legal: 1 or 2)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request, sampled only in IDLE
- src_base  in  BG_AW  background address of window top-left
- dst_base  in  PIC_AW  picture address of first written pixel
- win_w  in  8  window width in pixels
- win_h  in  8  window height in rows
- busy  out  1  high while a copy is in progress
- done  out  1  one-cycle pulse at completion
- bg_address  out  BG_AW  background s2 address
- bg_chipselect  out  1  background s2 chipselect
- bg_clken  out  1  background s2 clock enable
- bg_write  out  1  tied 0
- bg_writedata  out  DW  tied 0
- bg_byteenable  out  2  tied 2'b11
- bg_readdata  in  DW  background s2 read data
- pic_address  out  PIC_AW  picture s2 address
- pic_chipselect  out  1  picture s2 chipselect
- pic_clken  out  1  picture s2 clock enable
- pic_write  out  1  picture s2 write strobe
- pic_writedata  out  DW  picture s2 write data
- pic_byteenable  out  2  tied 2'b11
- Interface decision: one clock, clk; reset is asynchronous and active-low, reset_n.

Behaviour:
- Reset values: all outputs 0 except bg_byteenable and pic_byteenable, which are 2'b11; FSM in IDLE.
- bg_clken and pic_clken: held 1 whenever out of reset.
- States: IDLE, READ, DRAIN, DONE.
- IDLE: on start in cycle T:
  - latch src_base, dst_base, win_w, win_h.
  - If win_w==0 or win_h==0, go to DONE (no memory access). Otherwise go to READ.
- READ: one background read issued per cycle.
  - bg_chipselect=1; bg_address = row_ptr + col.
  - col runs 0..win_w-1. At col wrap, row_ptr += BG_STRIDE.
  - After the N = win_w*win_h-th read, go to DRAIN.
- Read pipeline: a valid bit and destination address are carried through an RD_LAT-deep delay line.
  - Write for pixel i occurs RD_LAT cycles after its read.
  - pic_write=1, pic_chipselect=1, pic_writedata=bg_readdata, pic_address=dst_base+i.
- DRAIN: no new reads. Leave after RD_LAT cycles, when the last write has issued, and go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Timing for N>0:
  - first read at T+1; last read at T+N.
  - last write at T+N+RD_LAT; done at T+N+RD_LAT+1.
  - busy is 1 from T+1 through T+N+RD_LAT, and 0 in the done cycle.
- Timing for N=0: busy stays 0; done at T+1.
- Address arithmetic: modulo 2^BG_AW and modulo 2^PIC_AW. Wrap-around is silent, with no error.
- Counters: pixel counter is 16 bits; no overflow is possible (max 255*255).
- start while not in IDLE: ignored. No queuing.
- Inputs changing mid-copy: no effect, because they were latched.
- reset_n asserted mid-copy: immediate abort. All strobes drop asynchronously and the FSM returns to IDLE. No done pulse is generated.

Optional Feature:
- Macro: LT24_BLIT_COLOR_KEY_EN.
- When defined:
  - Extra input port key_color [DW-1:0] and extra input port key_en [0:0].
  - key_color and key_en are latched at start.
  - With key_en=1, any pixel whose bg_readdata equals key_color is not written: pic_write=0 that cycle.
  - The destination address still advances for a skipped pixel, and timing is unchanged. This gives a transparent sprite overlay.
- When undefined: the ports are absent and every pixel is written.

Test Plan:
- Copy 4x2, RD_LAT=1, src_base=0x0010, dst_base=0x100:
  - reads at 0x010..0x013, then 0x090..0x093.
  - writes at 0x100..0x107 carrying the matching data.
  - done at T+10; busy high for 9 cycles.
- Zero-size, win_w=0, win_h=5: no chipselect activity; busy never asserts; done at T+1.
- Wrap-around, src_base=0x1FFE, win_w=4, win_h=1, dst_base=0xFFE:
  - reads at 0x1FFE, 0x1FFF, 0x0000, 0x0001.
  - writes at 0xFFE, 0xFFF, 0x000, 0x001.
- RD_LAT=2, 3x1 copy: each write lags its read by 2 cycles; done at T+6.
- start pulsed at T+3 during an active copy: ignored. Exactly one done pulse occurs, and the output trace is unchanged.
- reset_n low at T+3 of an 8x8 copy:
  - all strobes 0 immediately; no done pulse.
  - a new start after release performs a full, correct copy.
  - With LT24_BLIT_COLOR_KEY_EN defined, key_en=1 and key_color=0xF81F: pixels equal to 0xF81F are not written, and the other pixels are written at their normal addresses.
